// File: rtl/dav_pkg.sv
// Shared constants and FSM state type for the BCD-to-binary converter.
package dav_pkg;

   localparam int NUM_DIGITS = 6;
   localparam int DIGIT_W    = 4;
   localparam int VALUE_W    = 20;
   localparam int IDX_W      = 3;
   localparam int BCD_W      = NUM_DIGITS * DIGIT_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } conv_state_t;

endpackage : dav_pkg

// File: rtl/bcd_to_bin_digit_mac.sv
// Combinational multiply-by-ten-and-add step, truncated to VALUE_W bits,
// plus a flag for a nibble that is not a decimal digit.
module digit_mac
   import dav_pkg::*;
(
   input  logic [VALUE_W-1:0] acc,
   input  logic [DIGIT_W-1:0] digit,
   output logic [VALUE_W-1:0] result,
   output logic               digit_bad
);

   // acc*10 built from two shifts so no multiplier is inferred
   always_comb begin
      result    = (acc << 3) + (acc << 1) + VALUE_W'(digit);
      digit_bad = (digit > DIGIT_W'(9));
   end

endmodule : digit_mac

// File: rtl/bcd_to_bin.sv
// Six-digit BCD to binary converter, one digit per cycle, MSD first.
// Optional macro BCD_DIGIT_CHECK_EN: report non-decimal nibbles via error.
module bcd_to_bin
   import dav_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [BCD_W-1:0]   digits,
   output logic               busy,
   output logic               done,
   output logic [VALUE_W-1:0] value,
   output logic               error
);

   conv_state_t        state_q, state_d;
   logic [BCD_W-1:0]   digits_q, digits_d;
   logic [VALUE_W-1:0] acc_q, acc_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [VALUE_W-1:0] value_q, value_d;
   logic               error_q, error_d;
   logic [DIGIT_W-1:0] cur_digit;
   logic [VALUE_W-1:0] mac_result;
   logic               digit_bad;

`ifdef BCD_DIGIT_CHECK_EN
   logic               bad_seen_q, bad_seen_d;
`else
   logic               unused_digit_bad;
   assign unused_digit_bad = digit_bad;
`endif

   assign cur_digit = digits_q[idx_q*DIGIT_W +: DIGIT_W];

   digit_mac u_digit_mac (
      .acc       (acc_q),
      .digit     (cur_digit),
      .result    (mac_result),
      .digit_bad (digit_bad)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CONV;
         CONV:    if (idx_q == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
   end

   // Result registers are loaded on the last CONV edge so they are valid throughout DONE
   always_comb begin
      digits_d = digits_q;
      acc_d    = acc_q;
      idx_d    = idx_q;
      value_d  = value_q;
      error_d  = error_q;
`ifdef BCD_DIGIT_CHECK_EN
      bad_seen_d = bad_seen_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               digits_d = digits;
               acc_d    = '0;
               idx_d    = IDX_W'(NUM_DIGITS - 1);
`ifdef BCD_DIGIT_CHECK_EN
               bad_seen_d = 1'b0;
`endif
            end
         end
         CONV: begin
            acc_d = mac_result;
`ifdef BCD_DIGIT_CHECK_EN
            bad_seen_d = bad_seen_q | digit_bad;
`endif
            if (idx_q == '0) begin
`ifdef BCD_DIGIT_CHECK_EN
               value_d = (bad_seen_q | digit_bad) ? '0 : mac_result;
               error_d = bad_seen_q | digit_bad;
`else
               value_d = mac_result;
               error_d = 1'b0;
`endif
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digits_q <= '0;
         acc_q    <= '0;
         idx_q    <= '0;
         value_q  <= '0;
         error_q  <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
         bad_seen_q <= 1'b0;
`endif
      end else begin
         digits_q <= digits_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         value_q  <= value_d;
         error_q  <= error_d;
`ifdef BCD_DIGIT_CHECK_EN
         bad_seen_q <= bad_seen_d;
`endif
      end
   end

   assign value = value_q;
   assign error = error_q;

endmodule : bcd_to_bin

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin; inputs driven and outputs
// sampled on the falling clock edge.
module tb_bcd_to_bin;

   logic        clk;
   logic        rst;
   logic        start;
   logic [23:0] digits;
   logic        busy;
   logic        done;
   logic [19:0] value;
   logic        error;

   int          vectors;
   int          miscompares;
   logic [19:0] lastValue;
   logic        lastError;

   bcd_to_bin dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .digits (digits),
      .busy   (busy),
      .done   (done),
      .value  (value),
      .error  (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [19:0] actual,
                              input logic [19:0] expected);
      vectors++;
      assert (actual === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                tag, actual, actual, expected, expected);
      end
   endtask

   // Called at a falling edge with the DUT idle; start is taken on the next rising edge.
   task automatic applyStimulus(input logic [23:0] d, input logic [19:0] expVal,
                                input logic expErr, input bit disturb);
      digits = d;
      start  = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start  = 1'b0;
            digits = ~d;
         end
         checkOutput("busy", {19'd0, busy}, 20'd1);
         checkOutput("done", {19'd0, done}, (k == 7) ? 20'd1 : 20'd0);
         if (k < 7) begin
            checkOutput("value_hold", value, lastValue);
            checkOutput("error_hold", {19'd0, error}, {19'd0, lastError});
         end else begin
            checkOutput("value", value, expVal);
            checkOutput("error", {19'd0, error}, {19'd0, expErr});
         end
         if (disturb && k == 2) begin
            digits = 24'h999999;
            start  = 1'b1;
         end
         if (disturb && k == 3) start = 1'b0;
      end
      lastValue = expVal;
      lastError = expErr;
      @(negedge clk);
      checkOutput("idle_busy", {19'd0, busy}, 20'd0);
      checkOutput("idle_done", {19'd0, done}, 20'd0);
      checkOutput("idle_value", value, lastValue);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      lastValue   = '0;
      lastError   = 1'b0;
      rst         = 1'b1;
      start       = 1'b0;
      digits      = '0;

      repeat (2) @(negedge clk);
      checkOutput("rst_busy", {19'd0, busy}, 20'd0);
      checkOutput("rst_done", {19'd0, done}, 20'd0);
      checkOutput("rst_value", value, 20'd0);
      checkOutput("rst_error", {19'd0, error}, 20'd0);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(24'h123456, 20'h1E240, 1'b0, 1'b0);
      applyStimulus(24'h999999, 20'hF423F, 1'b0, 1'b0);
      applyStimulus(24'h000000, 20'd0, 1'b0, 1'b0);
      applyStimulus(24'h654321, 20'd654321, 1'b0, 1'b0);
`ifdef BCD_DIGIT_CHECK_EN
      applyStimulus(24'h12A456, 20'd0, 1'b1, 1'b0);
      applyStimulus(24'hFFFFFF, 20'd0, 1'b1, 1'b0);
`else
      applyStimulus(24'h12A456, 20'd130456, 1'b0, 1'b0);
      applyStimulus(24'hFFFFFF, 20'd618089, 1'b0, 1'b0);
`endif
      applyStimulus(24'h000321, 20'd321, 1'b0, 1'b1);

      // Abort in the third CONV cycle; previous value is nonzero so the clear is visible.
      digits = 24'h000777;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_busy", {19'd0, busy}, 20'd0);
      checkOutput("abort_done", {19'd0, done}, 20'd0);
      checkOutput("abort_value", value, 20'd0);
      checkOutput("abort_error", {19'd0, error}, 20'd0);
      lastValue = '0;
      lastError = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checkOutput("abort_no_done", {19'd0, done}, 20'd0);
      end
      applyStimulus(24'h000042, 20'd42, 1'b0, 1'b0);

      // Reset and start together: start must be dropped.
      rst    = 1'b1;
      start  = 1'b1;
      digits = 24'h000099;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      checkOutput("rst_start_busy", {19'd0, busy}, 20'd0);
      checkOutput("rst_start_value", value, 20'd0);
      @(negedge clk);
      checkOutput("rst_start_busy2", {19'd0, busy}, 20'd0);
      checkOutput("rst_start_done", {19'd0, done}, 20'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_bcd_to_bin
